// File: rtl/foc_pkg.sv
// Shared FOC definitions: word width, Q1.15 full scale and the inverse-Park
// sequencer state encoding.
package foc_pkg;

    localparam int DATA_WIDTH = 16;

    typedef logic signed [DATA_WIDTH-1:0] q15_t;

    localparam q15_t Q15_FULL_SCALE = 16'sd32767;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_INPUTS = 2'd1,
        LAUNCH      = 2'd2,
        WAIT_RESULT = 2'd3
    } seq_state_t;

endpackage

// File: rtl/foc_anti_park_sequencer_if.sv
// Signal bundle between the sequencer, the PI/angle/anti_park/SVPWM stages and
// the error-status consumer.
interface foc_anti_park_sequencer_if #(
    parameter int OW = 8
);
    import foc_pkg::*;

    logic            pwm_period_tick_in;
    logic            voltage_dq_valid_in;
    q15_t            voltage_d_in;
    q15_t            voltage_q_in;
    logic            phase_valid_in;
    q15_t            phase_sin_in;
    q15_t            phase_cos_in;
    logic            anti_park_cal_enable_out;
    q15_t            voltage_d_out;
    q15_t            voltage_q_out;
    q15_t            phase_sin_out;
    q15_t            phase_cos_out;
    q15_t            voltage_alpha_in;
    q15_t            voltage_beta_in;
    logic            anti_park_cal_valid_in;
    q15_t            voltage_alpha_out;
    q15_t            voltage_beta_out;
    logic            voltage_ab_valid_out;
    logic            busy_out;
    logic            timeout_err_out;
    logic [OW-1:0]   overrun_cnt_out;
    logic            clear_err_in;

    modport slave (
        input  pwm_period_tick_in, voltage_dq_valid_in, voltage_d_in, voltage_q_in,
        input  phase_valid_in, phase_sin_in, phase_cos_in,
        input  voltage_alpha_in, voltage_beta_in, anti_park_cal_valid_in, clear_err_in,
        output anti_park_cal_enable_out, voltage_d_out, voltage_q_out,
        output phase_sin_out, phase_cos_out, voltage_alpha_out, voltage_beta_out,
        output voltage_ab_valid_out, busy_out, timeout_err_out, overrun_cnt_out
    );

    modport master (
        output pwm_period_tick_in, voltage_dq_valid_in, voltage_d_in, voltage_q_in,
        output phase_valid_in, phase_sin_in, phase_cos_in,
        output voltage_alpha_in, voltage_beta_in, anti_park_cal_valid_in, clear_err_in,
        input  anti_park_cal_enable_out, voltage_d_out, voltage_q_out,
        input  phase_sin_out, phase_cos_out, voltage_alpha_out, voltage_beta_out,
        input  voltage_ab_valid_out, busy_out, timeout_err_out, overrun_cnt_out
    );

endinterface

// File: rtl/foc_anti_park_sequencer.sv
// Per-PWM-period sequencer for the inverse Park unit: gathers Ud/Uq and sin/cos,
// launches one calculation, forwards alpha/beta and reports timeouts/overruns.
module foc_anti_park_sequencer
    import foc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int OVR_CNT_WIDTH  = 8
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    foc_anti_park_sequencer_if.slave  bus
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t               state_q, state_d;
    logic [TIMER_W-1:0]       timer_q, timer_d;
    logic                     dq_full_q, dq_full_d;
    logic                     ph_full_q, ph_full_d;
    q15_t                     vd_lat_q, vd_lat_d, vq_lat_q, vq_lat_d;
    q15_t                     sin_lat_q, sin_lat_d, cos_lat_q, cos_lat_d;
    q15_t                     vd_out_q, vd_out_d, vq_out_q, vq_out_d;
    q15_t                     sin_out_q, sin_out_d, cos_out_q, cos_out_d;
    q15_t                     alpha_q, alpha_d, beta_q, beta_d;
    logic                     en_q, en_d;
    logic                     ab_valid_q, ab_valid_d;
    logic                     busy_q, busy_d;
    logic                     terr_q, terr_d;
    logic [OVR_CNT_WIDTH-1:0] ovr_q, ovr_d;

    logic [TIMER_W-1:0]       timer_inc_s;
    logic                     timeout_s;
    logic                     listen_s;
    logic                     tmo_fire_s;

    assign timer_inc_s = timer_q + TIMER_W'(1);
    assign timeout_s   = (timer_inc_s == TIMER_W'(TIMEOUT_CYCLES));
    // Latches accept strobes on the starting tick and throughout WAIT_INPUTS.
    assign listen_s    = ((state_q == IDLE) && bus.pwm_period_tick_in) || (state_q == WAIT_INPUTS);

    // Next-state, latch, operand, result and status computation.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        dq_full_d  = dq_full_q;
        ph_full_d  = ph_full_q;
        vd_out_d   = vd_out_q;
        vq_out_d   = vq_out_q;
        sin_out_d  = sin_out_q;
        cos_out_d  = cos_out_q;
        alpha_d    = alpha_q;
        beta_d     = beta_q;
        en_d       = 1'b0;
        ab_valid_d = 1'b0;
        tmo_fire_s = 1'b0;

        vd_lat_d  = (listen_s && bus.voltage_dq_valid_in) ? bus.voltage_d_in : vd_lat_q;
        vq_lat_d  = (listen_s && bus.voltage_dq_valid_in) ? bus.voltage_q_in : vq_lat_q;
        sin_lat_d = (listen_s && bus.phase_valid_in)      ? bus.phase_sin_in : sin_lat_q;
        cos_lat_d = (listen_s && bus.phase_valid_in)      ? bus.phase_cos_in : cos_lat_q;

        case (state_q)
            IDLE: begin
                if (bus.pwm_period_tick_in) begin
                    state_d   = WAIT_INPUTS;
                    timer_d   = '0;
                    dq_full_d = bus.voltage_dq_valid_in;
                    ph_full_d = bus.phase_valid_in;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_INPUTS: begin
                timer_d   = timer_inc_s;
                dq_full_d = dq_full_q | bus.voltage_dq_valid_in;
                ph_full_d = ph_full_q | bus.phase_valid_in;
                if (timeout_s) begin
                    state_d    = IDLE;
                    tmo_fire_s = 1'b1;
                end else if (dq_full_d && ph_full_d) begin
                    state_d   = LAUNCH;
                    en_d      = 1'b1;
                    vd_out_d  = vd_lat_d;
                    vq_out_d  = vq_lat_d;
                    sin_out_d = sin_lat_d;
                    cos_out_d = cos_lat_d;
                end else begin
                    state_d = WAIT_INPUTS;
                end
            end
            LAUNCH: begin
                timer_d = timer_inc_s;
                if (timeout_s) begin
                    state_d    = IDLE;
                    tmo_fire_s = 1'b1;
                end else begin
                    state_d = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                timer_d = timer_inc_s;
                if (bus.anti_park_cal_valid_in) begin
                    state_d    = IDLE;
                    alpha_d    = bus.voltage_alpha_in;
                    beta_d     = bus.voltage_beta_in;
                    ab_valid_d = 1'b1;
                end else if (timeout_s) begin
                    state_d    = IDLE;
                    tmo_fire_s = 1'b1;
                end else begin
                    state_d = WAIT_RESULT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        // Clear wins over a same-cycle timeout or dropped tick.
        terr_d = bus.clear_err_in ? 1'b0 : (terr_q | tmo_fire_s);
        ovr_d  = bus.clear_err_in ? '0
               : (bus.pwm_period_tick_in && (state_q != IDLE) && (ovr_q != '1)) ? ovr_q + OVR_CNT_WIDTH'(1)
               : ovr_q;
    end

    // State and output registers.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            dq_full_q  <= 1'b0;
            ph_full_q  <= 1'b0;
            vd_lat_q   <= '0;
            vq_lat_q   <= '0;
            sin_lat_q  <= '0;
            cos_lat_q  <= '0;
            vd_out_q   <= '0;
            vq_out_q   <= '0;
            sin_out_q  <= '0;
            cos_out_q  <= '0;
            alpha_q    <= '0;
            beta_q     <= '0;
            en_q       <= 1'b0;
            ab_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
            ovr_q      <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            dq_full_q  <= dq_full_d;
            ph_full_q  <= ph_full_d;
            vd_lat_q   <= vd_lat_d;
            vq_lat_q   <= vq_lat_d;
            sin_lat_q  <= sin_lat_d;
            cos_lat_q  <= cos_lat_d;
            vd_out_q   <= vd_out_d;
            vq_out_q   <= vq_out_d;
            sin_out_q  <= sin_out_d;
            cos_out_q  <= cos_out_d;
            alpha_q    <= alpha_d;
            beta_q     <= beta_d;
            en_q       <= en_d;
            ab_valid_q <= ab_valid_d;
            busy_q     <= busy_d;
            terr_q     <= terr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.anti_park_cal_enable_out = en_q;
    assign bus.voltage_d_out            = vd_out_q;
    assign bus.voltage_q_out            = vq_out_q;
    assign bus.phase_sin_out            = sin_out_q;
    assign bus.phase_cos_out            = cos_out_q;
    assign bus.voltage_alpha_out        = alpha_q;
    assign bus.voltage_beta_out         = beta_q;
    assign bus.voltage_ab_valid_out     = ab_valid_q;
    assign bus.busy_out                 = busy_q;
    assign bus.timeout_err_out          = terr_q;
    assign bus.overrun_cnt_out          = ovr_q;

endmodule

// File: tb/tb_foc_anti_park_sequencer.sv
// Bench for foc_anti_park_sequencer: directed vector table, random periods
// against a transaction-level model, and timeout/overrun/reset sequences.
module tb_foc_anti_park_sequencer;
    import foc_pkg::*;

    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    foc_anti_park_sequencer_if #(.OW(8)) bus   ();
    foc_anti_park_sequencer_if #(.OW(2)) bus_n ();

    foc_anti_park_sequencer #(.TIMEOUT_CYCLES(TMO), .OVR_CNT_WIDTH(8)) dut (
        .sys_clk(clk), .reset(rst), .bus(bus));
    foc_anti_park_sequencer #(.TIMEOUT_CYCLES(TMO), .OVR_CNT_WIDTH(2)) dut_n (
        .sys_clk(clk), .reset(rst), .bus(bus_n));

    assign bus_n.pwm_period_tick_in     = bus.pwm_period_tick_in;
    assign bus_n.voltage_dq_valid_in    = bus.voltage_dq_valid_in;
    assign bus_n.voltage_d_in           = bus.voltage_d_in;
    assign bus_n.voltage_q_in           = bus.voltage_q_in;
    assign bus_n.phase_valid_in         = bus.phase_valid_in;
    assign bus_n.phase_sin_in           = bus.phase_sin_in;
    assign bus_n.phase_cos_in           = bus.phase_cos_in;
    assign bus_n.voltage_alpha_in       = bus.voltage_alpha_in;
    assign bus_n.voltage_beta_in        = bus.voltage_beta_in;
    assign bus_n.anti_park_cal_valid_in = bus.anti_park_cal_valid_in;
    assign bus_n.clear_err_in           = bus.clear_err_in;

    typedef struct {
        int   tp, td, td2;
        q15_t d, q, d2, q2, s, c;
        int   lat;
        int   exp_launch;
        q15_t exp_d, exp_q, exp_alpha, exp_beta;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    string cur_tag;
    q15_t  last_alpha, last_beta;
    q15_t  drv_a, drv_b;
    vec_t  vecs [4];

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %0d wanted %0d at %0t", cur_tag, name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.pwm_period_tick_in     = 1'b0;
        bus.voltage_dq_valid_in    = 1'b0;
        bus.phase_valid_in         = 1'b0;
        bus.anti_park_cal_valid_in = 1'b0;
        bus.clear_err_in           = 1'b0;
        bus.voltage_d_in           = q15_t'($urandom);
        bus.voltage_q_in           = q15_t'($urandom);
        bus.phase_sin_in           = q15_t'($urandom);
        bus.phase_cos_in           = q15_t'($urandom);
        bus.voltage_alpha_in       = q15_t'($urandom);
        bus.voltage_beta_in        = q15_t'($urandom);
    endtask

    // Behavioural anti_park: products scaled by the Q1.15 full scale, saturated.
    function automatic q15_t q15_div(input longint x);
        longint r;
        r = x / longint'(Q15_FULL_SCALE);
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return q15_t'(r);
    endfunction

    function automatic q15_t model_alpha(input q15_t d, input q15_t q, input q15_t s, input q15_t c);
        return q15_div(longint'(d) * longint'(c) - longint'(q) * longint'(s));
    endfunction

    function automatic q15_t model_beta(input q15_t d, input q15_t q, input q15_t s, input q15_t c);
        return q15_div(longint'(d) * longint'(s) + longint'(q) * longint'(c));
    endfunction

    // Random period: launch follows the later of the first phase / first dq strobe,
    // operands are the latest strobe seen before launch.
    function automatic vec_t rand_vec();
        vec_t v;
        int   first_dq, lc, best;
        v.tp  = int'($urandom_range(0, 15));
        v.td  = int'($urandom_range(0, 15));
        v.td2 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : -1;
        if (v.td2 == v.td) v.td2 = -1;
        v.d = q15_t'($urandom);  v.q = q15_t'($urandom);
        v.d2 = q15_t'($urandom); v.q2 = q15_t'($urandom);
        v.s = q15_t'($urandom);  v.c = q15_t'($urandom);
        v.lat = int'($urandom_range(1, 8));
        first_dq = (v.td2 >= 0 && v.td2 < v.td) ? v.td2 : v.td;
        v.exp_launch = ((v.tp > first_dq) ? v.tp : first_dq) + 1;
        if (v.exp_launch < 2) v.exp_launch = 2;
        lc = v.exp_launch - 1;
        best = -1;
        if (v.td <= lc) begin
            best = v.td; v.exp_d = v.d; v.exp_q = v.q;
        end
        if (v.td2 >= 0 && v.td2 <= lc && v.td2 > best) begin
            v.exp_d = v.d2; v.exp_q = v.q2;
        end
        v.exp_alpha = model_alpha(v.exp_d, v.exp_q, v.s, v.c);
        v.exp_beta  = model_beta(v.exp_d, v.exp_q, v.s, v.c);
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int   res_k, last;
        q15_t ma, mb;
        res_k = v.exp_launch + v.lat;
        last  = res_k + 2;
        if (v.td2 + 1 > last) last = v.td2 + 1;
        ma = model_alpha(v.exp_d, v.exp_q, v.s, v.c);
        mb = model_beta(v.exp_d, v.exp_q, v.s, v.c);
        for (int k = 0; k <= last; k++) begin
            chk("en", bus.anti_park_cal_enable_out, k == v.exp_launch);
            chk("busy", bus.busy_out, (k >= 1) && (k <= res_k));
            chk("ab_valid", bus.voltage_ab_valid_out, k == res_k + 1);
            if (k >= v.exp_launch && k <= res_k) begin
                chk("d_out", bus.voltage_d_out, v.exp_d);
                chk("q_out", bus.voltage_q_out, v.exp_q);
                chk("sin_out", bus.phase_sin_out, v.s);
                chk("cos_out", bus.phase_cos_out, v.c);
            end
            if (k == res_k + 1) begin
                chk("alpha", bus.voltage_alpha_out, v.exp_alpha);
                chk("beta", bus.voltage_beta_out, v.exp_beta);
            end
            set_idle();
            bus.pwm_period_tick_in = (k == 0);
            if (k == v.tp) begin
                bus.phase_valid_in = 1'b1; bus.phase_sin_in = v.s; bus.phase_cos_in = v.c;
            end
            if (k == v.td) begin
                bus.voltage_dq_valid_in = 1'b1; bus.voltage_d_in = v.d; bus.voltage_q_in = v.q;
            end
            if (k == v.td2) begin
                bus.voltage_dq_valid_in = 1'b1; bus.voltage_d_in = v.d2; bus.voltage_q_in = v.q2;
            end
            if (k == res_k) begin
                bus.anti_park_cal_valid_in = 1'b1; bus.voltage_alpha_in = ma; bus.voltage_beta_in = mb;
            end
            if (k == 1) bus.anti_park_cal_valid_in = 1'b1;
            next_cycle();
        end
        last_alpha = v.exp_alpha;
        last_beta  = v.exp_beta;
    endtask

    task automatic chk_all_zero();
        chk("z_en", bus.anti_park_cal_enable_out, 0);
        chk("z_ab_valid", bus.voltage_ab_valid_out, 0);
        chk("z_busy", bus.busy_out, 0);
        chk("z_err", bus.timeout_err_out, 0);
        chk("z_ovr", bus.overrun_cnt_out, 0);
        chk("z_alpha", bus.voltage_alpha_out, 0);
        chk("z_beta", bus.voltage_beta_out, 0);
        chk("z_d", bus.voltage_d_out, 0);
        chk("z_q", bus.voltage_q_out, 0);
        chk("z_sin", bus.phase_sin_out, 0);
        chk("z_cos", bus.phase_cos_out, 0);
    endtask

    initial begin
        vecs[0] = '{tp:0, td:0, td2:-1, d:16'sd0, q:16'sd16383, d2:16'sd0, q2:16'sd0,
                    s:16'sd32767, c:16'sd0, lat:4, exp_launch:2,
                    exp_d:16'sd0, exp_q:16'sd16383, exp_alpha:-16'sd16383, exp_beta:16'sd0};
        vecs[1] = '{tp:3, td:10, td2:-1, d:16'sd16383, q:16'sd16383, d2:16'sd0, q2:16'sd0,
                    s:16'sd0, c:16'sd32767, lat:4, exp_launch:11,
                    exp_d:16'sd16383, exp_q:16'sd16383, exp_alpha:16'sd16383, exp_beta:16'sd16383};
        vecs[2] = '{tp:8, td:2, td2:5, d:16'sd1000, q:16'sd500, d2:-16'sd2000, q2:16'sd700,
                    s:16'sd0, c:16'sd32767, lat:3, exp_launch:9,
                    exp_d:-16'sd2000, exp_q:16'sd700, exp_alpha:-16'sd2000, exp_beta:16'sd700};
        vecs[3] = '{tp:0, td:1, td2:4, d:16'sd300, q:-16'sd400, d2:16'sd9999, q2:16'sd9999,
                    s:16'sd23170, c:16'sd23170, lat:2, exp_launch:2,
                    exp_d:16'sd300, exp_q:-16'sd400, exp_alpha:16'sd494, exp_beta:-16'sd70};

        rst = 1'b1;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cur_tag = "reset";
        chk_all_zero();

        for (int i = 0; i < 4; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            run_txn(vecs[i]);
        end

        for (int i = 0; i < 40; i++) begin
            cur_tag = $sformatf("rand%0d", i);
            run_txn(rand_vec());
        end

        // Result never arrives: abort after the timeout, keep old alpha/beta.
        cur_tag = "timeout";
        for (int k = 0; k <= 70; k++) begin
            chk("en", bus.anti_park_cal_enable_out, k == 2);
            chk("ab_valid", bus.voltage_ab_valid_out, 0);
            chk("busy", bus.busy_out, (k >= 1) && (k <= TMO));
            chk("err", bus.timeout_err_out, k >= TMO + 1);
            if (k == 0 || k == 70) begin
                chk("alpha_hold", bus.voltage_alpha_out, last_alpha);
                chk("beta_hold", bus.voltage_beta_out, last_beta);
            end
            set_idle();
            bus.pwm_period_tick_in  = (k == 0);
            bus.voltage_dq_valid_in = (k == 0);
            bus.phase_valid_in      = (k == 0);
            next_cycle();
        end
        cur_tag = "after_timeout";
        run_txn(vecs[0]);
        chk("err_sticky", bus.timeout_err_out, 1);

        // Ticks while busy are counted; clear beats a coincident dropped tick.
        cur_tag = "overrun";
        drv_a = q15_t'($urandom);
        drv_b = q15_t'($urandom);
        for (int k = 0; k <= 18; k++) begin
            if (k == 8) begin
                chk("ovr3", bus.overrun_cnt_out, 3);
                chk("ovr3_n", bus_n.overrun_cnt_out, 3);
                chk("err_set", bus.timeout_err_out, 1);
            end
            if (k == 12) begin
                chk("ovr5", bus.overrun_cnt_out, 5);
                chk("ovr5_sat_n", bus_n.overrun_cnt_out, 3);
            end
            if (k == 14) begin
                chk("ovr_clr", bus.overrun_cnt_out, 0);
                chk("ovr_clr_n", bus_n.overrun_cnt_out, 0);
                chk("err_clr", bus.timeout_err_out, 0);
            end
            chk("busy", bus.busy_out, (k >= 1) && (k <= 14));
            chk("ab_valid", bus.voltage_ab_valid_out, k == 15);
            if (k == 15) begin
                chk("alpha", bus.voltage_alpha_out, drv_a);
                chk("beta", bus.voltage_beta_out, drv_b);
            end
            set_idle();
            bus.pwm_period_tick_in  = (k == 0) || (k == 3) || (k == 5) || (k == 7) ||
                                      (k == 9) || (k == 11) || (k == 13);
            bus.voltage_dq_valid_in = (k == 0);
            bus.phase_valid_in      = (k == 0);
            bus.clear_err_in        = (k == 13);
            if (k == 14) begin
                bus.anti_park_cal_valid_in = 1'b1;
                bus.voltage_alpha_in = drv_a;
                bus.voltage_beta_in  = drv_b;
            end
            next_cycle();
        end

        // Reset in WAIT_RESULT, then a stray result must be ignored.
        cur_tag = "mid_reset";
        for (int k = 0; k <= 3; k++) begin
            set_idle();
            bus.pwm_period_tick_in  = (k == 0) || (k == 2);
            bus.voltage_dq_valid_in = (k == 0);
            bus.phase_valid_in      = (k == 0);
            next_cycle();
        end
        chk("busy_pre", bus.busy_out, 1);
        chk("ovr_pre", bus.overrun_cnt_out, 1);
        rst = 1'b1;
        #1;
        chk_all_zero();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_idle();
            bus.anti_park_cal_valid_in = 1'b1;
            next_cycle();
            chk_all_zero();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/foc_anti_park_sequencer.md
Name: foc_anti_park_sequencer

Overview:
Per-PWM-period controller that sequences the inverse Park datapath (anti_park_unit) in the FOC current loop. On each PWM period tick it collects Ud/Uq from the current PI stage and sin/cos of the electrical angle from the angle stage. It launches one anti_park_unit calculation with operands held stable, then captures U_alpha/U_beta and hands them to the SVPWM stage. It also detects result timeouts and PWM-tick overruns and reports them as status.

Parameters:
DATA_WIDTH, `DATA_WIDTH (16), width of all voltage/trig words, signed Q1.15 (full scale 2^15-1).
TIMEOUT_CYCLES, 64, max sys_clk cycles from tick to result before abort.
OVR_CNT_WIDTH, 8, width of saturating overrun counter.

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pwm_period_tick_in  in  1  one-cycle pulse, start of PWM period
voltage_dq_valid_in  in  1  Ud/Uq valid strobe from PI stage
voltage_d_in  in  DATA_WIDTH  Ud
voltage_q_in  in  DATA_WIDTH  Uq
phase_valid_in  in  1  sin/cos valid strobe from angle stage
phase_sin_in  in  DATA_WIDTH  sin(theta)
phase_cos_in  in  DATA_WIDTH  cos(theta)
anti_park_cal_enable_out  out  1  one-cycle launch pulse to anti_park_unit
voltage_d_out, voltage_q_out  out  DATA_WIDTH each  held operands to anti_park_unit
phase_sin_out, phase_cos_out  out  DATA_WIDTH each  held operands to anti_park_unit
voltage_alpha_in, voltage_beta_in  in  DATA_WIDTH each  anti_park_unit results
anti_park_cal_valid_in  in  1  anti_park_unit result valid
voltage_alpha_out, voltage_beta_out  out  DATA_WIDTH each  registered results to SVPWM
voltage_ab_valid_out  out  1  one-cycle pulse, new alpha/beta
busy_out  out  1  high when state != IDLE
timeout_err_out  out  1  sticky timeout flag
overrun_cnt_out  out  OVR_CNT_WIDTH  saturating count of dropped ticks
clear_err_in  in  1  clears timeout_err_out and overrun_cnt_out

Behaviour:
- Reset: state IDLE; all outputs 0; both input latches empty; timer 0.
- State IDLE:
  - on tick, clear both latches, start timer at 0, and go to WAIT_INPUTS.
  - If a strobe is coincident with the tick, capture it in that same cycle.
- State WAIT_INPUTS:
  - capture Ud/Uq on voltage_dq_valid_in; capture sin/cos on phase_valid_in.
  - A repeat strobe overwrites the earlier value (latest wins).
  - When both latches are full, go to LAUNCH.
- State LAUNCH:
  - drive anti_park_cal_enable_out=1 for exactly one cycle with operand outputs already stable.
  - Then go to WAIT_RESULT.
  - Operand outputs stay unchanged until the next LAUNCH.
- State WAIT_RESULT:
  - on anti_park_cal_valid_in, register alpha/beta and pulse voltage_ab_valid_out the next cycle.
  - Then go to IDLE.
- Latency:
  - strobes coincident with the tick (cycle 0) give LAUNCH in cycle 2.
  - valid_in in cycle N gives ab_valid_out and new data in cycle N+1.
- Timer:
  - increments every cycle in WAIT_INPUTS, LAUNCH and WAIT_RESULT.
  - On reaching TIMEOUT_CYCLES, set timeout_err_out and go to IDLE.
  - No ab_valid pulse is issued; alpha/beta outputs keep their previous values.
- Overrun:
  - a tick while not in IDLE is dropped and the current calculation continues.
  - overrun_cnt increments and saturates at all-ones.
- anti_park_cal_valid_in outside WAIT_RESULT is ignored.
- clear_err_in:
  - has priority over a same-cycle set or increment.
  - clears the flags only; state is not affected.
- Data passes through unmodified. Saturation is done inside anti_park_unit; there is no arithmetic here.
- Asserting reset mid-calculation returns to IDLE immediately. A later stray valid_in is ignored.

Decomposition:
- Shared package foc_pkg:
  - DATA_WIDTH;
  - Q15 full-scale constant 2^15-1;
  - seq_state_t enum {IDLE, WAIT_INPUTS, LAUNCH, WAIT_RESULT}.
- No sub-module is needed. The timer and overrun counter stay inline, and the block connects to anti_park_unit at the next level up.

Test Plan:
- Angle 90 deg (sin=32767, cos=0), Ud=0, Uq=16383, tick with both strobes in the same cycle; behavioural anti_park model with latency 4 -> one enable pulse in cycle 2, alpha=-16383, beta=0, ab_valid pulse in cycle 7.
- Staggered inputs (phase strobe at +3, dq strobe at +10, angle 0, Ud=Uq=16383) -> LAUNCH in cycle 11; operands held through WAIT_RESULT; alpha=16383, beta=16383.
- Model never returns valid -> timeout_err_out=1 at TIMEOUT_CYCLES=64 after tick; no ab_valid; alpha/beta unchanged; the next tick runs normally.
- Three ticks during busy -> overrun_cnt_out=3; with OVR_CNT_WIDTH=2, five such ticks -> 3 (saturated); clear_err_in -> 0.
- Reset asserted in WAIT_RESULT, then stray valid_in -> all outputs 0, no ab_valid pulse.
- Two dq strobes before the phase strobe (values 1000, then -2000) -> voltage_d_out=-2000 at LAUNCH.
